tetris_grid: RTL
================

# tetris_grid

Playfield storage for the Tetris display pipeline: a ROWS×COLS occupancy grid held in registers. Its read port feeds the video colour stage one row per request. Its write port takes piece placements from game logic. An internal line-clear engine sweeps the grid, removes full rows and shifts the rows above downward.

## Interface
- ROWS, 20, number of grid rows; row 0 is the top row.
- COLS, 14, number of columns; bit 0 is the leftmost column.
- AW, 5, row address width.
- gfx_clk  in  1  clock (25 MHz pixel clock).
- rst  in  1  reset; synchronous, active-high.
- vid_addr  in  AW  row requested by the video colour stage.
- vid_data  out  [0:COLS-1]  registered contents of row vid_addr.
- wr_en  in  1  write strobe, single cycle.
- wr_row  in  AW  target row of the write.
- wr_data  in  [0:COLS-1]  write data.
- wr_merge  in  1  write mode: 0 = overwrite row, 1 = OR wr_data into the row.
- clr_start  in  1  start a line-clear sweep; pulse.
- busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse when a sweep completes.
- lines  out  5  count of rows removed by the last sweep.

## Operation
- Storage is ROWS registers of COLS bits. Reset clears all rows.
- Read port:
  - vid_data <= row[vid_addr] on every edge.
  - vid_addr >= ROWS returns 0.
  - Reads are never blocked. During a sweep the display shows intermediate grid states.
- Write port:
  - Active only in IDLE. Writes while busy are dropped.
  - wr_row >= ROWS is ignored.
  - wr_merge=1 stores row | wr_data.
- FSM states: IDLE, CHECK, SHIFT, DONE.
  - IDLE: clr_start -> CHECK with r = ROWS-1 and lines = 0. A clr_start while not in IDLE is ignored.
  - CHECK:
    - row[r] all ones -> lines+1, s = r, go to SHIFT.
    - Else if r == 0 -> DONE.
    - Else r-1 and stay in CHECK.
  - SHIFT:
    - s > 0: row[s] <= row[s-1], s-1.
    - s == 0: row[0] <= 0, return to CHECK with r unchanged, so the row that moved into r is re-checked.
  - DONE: one cycle, then IDLE.
- Outputs: busy = (state != IDLE); clr_done = (state == DONE).
- lines is 5 bits and covers all ROWS removed. It holds its value until the next accepted clr_start.
- wr_en and clr_start in the same IDLE cycle: the write lands on that edge, and the first CHECK sees the written data.

## Timing
- Reset values: all rows 0, vid_data 0, busy 0, clr_done 0, lines 0, state IDLE.
- Read latency: 1 cycle (address at edge k, data valid after edge k).
- Write latency: 1 cycle. The written value is readable at the edge after the write edge.
- Sweep cost:
  - 1 cycle per CHECK.
  - r+1 cycles per removed row at position r.
  - 1 cycle for DONE.
  - Empty grid: busy for 21 cycles after the start edge; clr_done in cycle 21.
- rst mid-sweep aborts immediately to the reset state. No partial shift survives.

## Configuration
- TETRIS_GRID_LINE_CLEAR_EN defined: the FSM is built as described above.
- Not defined:
  - No FSM is built; clr_start is ignored.
  - busy, clr_done and lines are tied to 0.
  - Writes are always accepted.

## Structure
- Shared package tetris_pkg holds:
  - GRID_ROWS = 20, GRID_COLS = 14, GRID_AW = 5.
  - The grid state enum: IDLE, CHECK, SHIFT, DONE.
  - The colour constants used by the video stage.
- One sub-module, grid_clear_ctrl:
  - Contains the FSM and the r, s and lines counters.
  - Inputs: a row-full flag.
  - Outputs: row select, shift enable and zero-fill enable.
  - The grid registers stay in the parent.

## Test plan
- Reset, then vid_addr 0..19 and 25 -> vid_data = 0 for every address, one cycle after each request.
- Overwrite row 19 with all ones -> read of row 19 returns 14'b11111111111111 one cycle later; row 18 still reads 0.
- Overwrite row 5 with 0x00F0, then merge 0x0F00 -> row 5 reads 0x0FF0.
- Rows 19 and 18 full, row 17 = 0x0001, clr_start ->
  - busy for 63 cycles; clr_done in cycle 63.
  - lines = 2.
  - row 19 = 0x0001; rows 0..18 = 0.
- During a sweep, issue wr_en to row 3 and a second clr_start -> both ignored: row 3 unchanged, only one clr_done pulse.
- Row 0 full, clr_start, then rst 3 cycles later -> busy=0, lines=0, all rows 0 on the next edge, and no clr_done pulse.

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared constants and types for the Tetris playfield.
//   GRID_ROWS / GRID_COLS / GRID_AW : playfield geometry and row address width
//   grid_state_t                    : line-clear engine states
//   COLOR_*                         : 12-bit RGB colours used by the video stage
package tetris_pkg;

    localparam int GRID_ROWS = 20;
    localparam int GRID_COLS = 14;
    localparam int GRID_AW   = 5;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SHIFT,
        DONE
    } grid_state_t;

    localparam logic [11:0] COLOR_EMPTY  = 12'h000;
    localparam logic [11:0] COLOR_BLOCK  = 12'h0CF;
    localparam logic [11:0] COLOR_BORDER = 12'h888;

endpackage

// File: rtl/grid_clear_ctrl.sv
// grid_clear_ctrl: line-clear sequencer for tetris_grid.
// Walks rows bottom-up (r), and for each full row shifts everything above it
// down by one (s walks from r to 0), zero-filling row 0 at the end.
// Built only when TETRIS_GRID_LINE_CLEAR_EN is defined; otherwise all outputs
// are tied low and clr_start is ignored.
// Ports:
//   gfx_clk, rst  : clock, synchronous active-high reset
//   clr_start     : start a sweep (accepted in IDLE only)
//   row_full      : parent's all-ones flag for grid[row_sel]
//   row_sel       : row under test (CHECK) or shift destination (SHIFT)
//   shift_en      : copy row_sel-1 into row_sel
//   zero_en       : clear row 0 (last step of a shift)
//   busy          : sweep in progress
//   clr_done      : one-cycle pulse in DONE
//   lines         : rows removed by the last sweep
module grid_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS = GRID_ROWS,
    parameter int AW   = GRID_AW
) (
    input  logic          gfx_clk,
    input  logic          rst,
    input  logic          clr_start,
    input  logic          row_full,
    output logic [AW-1:0] row_sel,
    output logic          shift_en,
    output logic          zero_en,
    output logic          busy,
    output logic          clr_done,
    output logic [4:0]    lines
);

`ifdef TETRIS_GRID_LINE_CLEAR_EN
    grid_state_t   state;
    logic [AW-1:0] r;
    logic [AW-1:0] s;

    assign row_sel  = (state == SHIFT) ? s : r;
    assign shift_en = (state == SHIFT) && (s != '0);
    assign zero_en  = (state == SHIFT) && (s == '0);

    // busy/clr_done are registered alongside the state so they match
    // (state != IDLE) and (state == DONE) exactly.
    always_ff @(posedge gfx_clk) begin
        if (rst) begin
            state    <= IDLE;
            r        <= '0;
            s        <= '0;
            lines    <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CHECK;
                        r     <= AW'(ROWS - 1);
                        lines <= '0;
                        busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (row_full) begin
                        lines <= lines + 1'b1;
                        s     <= r;
                        state <= SHIFT;
                    end else if (r == '0) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end else begin
                        r <= r - 1'b1;
                    end
                end
                SHIFT: begin
                    // r is left alone so the row that dropped into r is re-checked
                    if (s != '0) s <= s - 1'b1;
                    else         state <= CHECK;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = ^{gfx_clk, rst, clr_start, row_full};

    assign row_sel  = '0;
    assign shift_en = 1'b0;
    assign zero_en  = 1'b0;
    assign busy     = 1'b0;
    assign clr_done = 1'b0;
    assign lines    = '0;
`endif

endmodule

// File: rtl/tetris_grid.sv
// tetris_grid: ROWS x COLS occupancy grid for the Tetris display pipeline.
// Registered read port for the video stage, row write/merge port for game
// logic, and an optional line-clear engine (grid_clear_ctrl), enabled with
// TETRIS_GRID_LINE_CLEAR_EN.
// Ports:
//   gfx_clk, rst      : clock, synchronous active-high reset
//   vid_addr/vid_data : row read, 1-cycle latency, out-of-range reads give 0
//   wr_en/wr_row/wr_data/wr_merge : row write (overwrite or OR-merge),
//                       dropped while busy or when wr_row >= ROWS
//   clr_start         : start a line-clear sweep
//   busy/clr_done/lines : sweep status and removed-row count
module tetris_grid
    import tetris_pkg::*;
#(
    parameter int ROWS = GRID_ROWS,
    parameter int COLS = GRID_COLS,
    parameter int AW   = GRID_AW
) (
    input  logic            gfx_clk,
    input  logic            rst,
    input  logic [AW-1:0]   vid_addr,
    output logic [0:COLS-1] vid_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_row,
    input  logic [0:COLS-1] wr_data,
    input  logic            wr_merge,
    input  logic            clr_start,
    output logic            busy,
    output logic            clr_done,
    output logic [4:0]      lines
);

    logic [0:COLS-1] grid  [ROWS];
    logic [0:COLS-1] above [ROWS];   // shift source for each row; row 0 takes zeros
    logic [AW-1:0]   row_sel;
    logic            row_full;
    logic            shift_en;
    logic            zero_en;
    logic            wr_hit;

    assign row_full = &grid[row_sel];
    assign wr_hit   = wr_en && !busy && (wr_row < AW'(ROWS));

    always_comb begin
        above[0] = '0;
        for (int i = 1; i < ROWS; i++) above[i] = grid[i-1];
    end

    // Writes only happen in IDLE and shifts only in SHIFT, so the two
    // update paths never compete for a row.
    always_ff @(posedge gfx_clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) grid[i] <= '0;
            vid_data <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (wr_hit && wr_row == AW'(i))
                    grid[i] <= wr_merge ? (grid[i] | wr_data) : wr_data;
                else if ((shift_en || zero_en) && row_sel == AW'(i))
                    grid[i] <= above[i];
            end
            vid_data <= (vid_addr < AW'(ROWS)) ? grid[vid_addr] : '0;
        end
    end

    grid_clear_ctrl #(
        .ROWS (ROWS),
        .AW   (AW)
    ) u_ctrl (
        .gfx_clk   (gfx_clk),
        .rst       (rst),
        .clr_start (clr_start),
        .row_full  (row_full),
        .row_sel   (row_sel),
        .shift_en  (shift_en),
        .zero_en   (zero_en),
        .busy      (busy),
        .clr_done  (clr_done),
        .lines     (lines)
    );

endmodule
